// File: rtl/led_master_pkg.sv
// Shared types and constants for the LED walking-one bus master.
// No logic of its own: state encoding, reset pattern, register offset and the rotate helper.
package led_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDWAIT,
        CHECK,
        WAIT
    } led_master_state_t;

    localparam logic [7:0]  LED_PATTERN_INIT = 8'h01;
    localparam int unsigned LED_REG_OFFSET   = 0;

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/avm_single_master.sv
// One-outstanding-transaction Avalon-MM initiator: registered command, accept, read capture, read timeout.
// Command appears the edge after req_vld_i; it is held stable while waitrequest is high.
module avm_single_master #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_vld_i,
    input  logic        req_wr_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdat_i,
    output logic        wr_acc_o,
    output logic        rd_acc_o,
    output logic        rsp_vld_o,
    output logic        rsp_timeout_o,
    output logic [31:0] rsp_dat_o,
    output logic [31:0] avm_address_o,
    output logic        avm_read_o,
    output logic        avm_write_o,
    output logic [31:0] avm_writedata_o,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_waitrequest_i,
    input  logic        avm_readdatavalid_i
);

    localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [31:0]     address_q, address_d;
    logic [31:0]     wdat_q, wdat_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic            pend_q, pend_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_hit;

    assign wr_acc_o      = write_q & ~avm_waitrequest_i;
    assign rd_acc_o      = read_q & ~avm_waitrequest_i;
    // Data arriving in the last allowed cycle still counts as a response.
    assign to_hit        = pend_q & ~avm_readdatavalid_i & (to_cnt_q == TO_LAST);
    assign rsp_vld_o     = (pend_q & avm_readdatavalid_i) | to_hit;
    assign rsp_timeout_o = to_hit;
    assign rsp_dat_o     = avm_readdata_i;

    always_comb begin
        address_d = address_q;
        wdat_d    = wdat_q;
        read_d    = read_q;
        write_d   = write_q;
        pend_d    = pend_q;
        to_cnt_d  = to_cnt_q;

        if (wr_acc_o || rd_acc_o) begin
            address_d = '0;
            wdat_d    = '0;
            read_d    = 1'b0;
            write_d   = 1'b0;
        end

        if (rd_acc_o) begin
            pend_d   = 1'b1;
            to_cnt_d = '0;
        end else if (pend_q) begin
            if (rsp_vld_o) begin
                pend_d = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        // A new request may land in the same cycle the previous command is accepted.
        if (req_vld_i) begin
            address_d = req_addr_i;
            write_d   = req_wr_i;
            read_d    = ~req_wr_i;
            wdat_d    = req_wr_i ? req_wdat_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            address_q <= '0;
            wdat_q    <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            pend_q    <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            address_q <= address_d;
            wdat_q    <= wdat_d;
            read_q    <= read_d;
            write_q   <= write_d;
            pend_q    <= pend_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign avm_address_o   = address_q;
    assign avm_read_o      = read_q;
    assign avm_write_o     = write_q;
    assign avm_writedata_o = wdat_q;

endmodule

// File: rtl/led_pattern_master.sv
// Walking-one LED self-test master: write pattern, read it back, compare, wait PERIOD cycles, rotate.
// Write issues the edge after enable; every bus phase stretches under waitrequest, readback bounded by TIMEOUT.
module led_pattern_master
    import led_master_pkg::*;
#(
    parameter int unsigned PERIOD   = 50_000_000,
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] LED_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    output logic [31:0] avm_m0_address,
    output logic        avm_m0_read,
    output logic        avm_m0_write,
    output logic [31:0] avm_m0_writedata,
    input  logic [31:0] avm_m0_readdata,
    input  logic        avm_m0_waitrequest,
    input  logic        avm_m0_readdatavalid,
    output logic [7:0]  pattern,
    output logic        busy,
    output logic        mismatch,
    output logic        timeout
);

    localparam int unsigned WAIT_W   = $clog2(PERIOD);
    localparam logic [31:0] REG_ADDR = LED_ADDR + 32'(LED_REG_OFFSET * 4);

    led_master_state_t state_q, state_d;
    logic [7:0]        pattern_q, pattern_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mismatch_q, mismatch_d;
    logic              timeout_q, timeout_d;
    logic              busy_q;

    logic              req_vld, req_wr;
    logic [31:0]       req_addr, req_wdat;
    logic              wr_acc, rd_acc, rsp_vld, rsp_timeout;
    logic [31:0]       rsp_dat;
    logic [31:0]       rd_diff;

    // Only the low byte carries the LED state; the upper readback bits are masked off.
    assign rd_diff = (rsp_dat ^ {24'b0, pattern_q}) & 32'h0000_00FF;

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        wait_cnt_d = wait_cnt_q;
        mismatch_d = mismatch_q & ~clear;
        timeout_d  = timeout_q & ~clear;
        req_vld    = 1'b0;
        req_wr     = 1'b0;
        req_addr   = REG_ADDR;
        req_wdat   = {24'b0, pattern_q};

        case (state_q)
            IDLE: begin
                if (enable) begin
                    req_vld = 1'b1;
                    req_wr  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (wr_acc) begin
                    req_vld = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_acc) begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                if (rsp_vld) begin
                    state_d = CHECK;
                    if (rsp_timeout) begin
                        timeout_d = 1'b1;
                    end else if (|rd_diff) begin
                        mismatch_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                pattern_d = rotl8(pattern_q);
                if (enable) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_W'(PERIOD - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == '0) begin
                    req_vld = 1'b1;
                    req_wr  = 1'b1;
                    state_d = WRITE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pattern_q  <= LED_PATTERN_INIT;
            wait_cnt_q <= '0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            wait_cnt_q <= wait_cnt_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    avm_single_master #(
        .TIMEOUT (TIMEOUT)
    ) u_avm (
        .clk_i               (clk),
        .reset_ni            (reset_n),
        .req_vld_i           (req_vld),
        .req_wr_i            (req_wr),
        .req_addr_i          (req_addr),
        .req_wdat_i          (req_wdat),
        .wr_acc_o            (wr_acc),
        .rd_acc_o            (rd_acc),
        .rsp_vld_o           (rsp_vld),
        .rsp_timeout_o       (rsp_timeout),
        .rsp_dat_o           (rsp_dat),
        .avm_address_o       (avm_m0_address),
        .avm_read_o          (avm_m0_read),
        .avm_write_o         (avm_m0_write),
        .avm_writedata_o     (avm_m0_writedata),
        .avm_readdata_i      (avm_m0_readdata),
        .avm_waitrequest_i   (avm_m0_waitrequest),
        .avm_readdatavalid_i (avm_m0_readdatavalid)
    );

    assign pattern  = pattern_q;
    assign busy     = busy_q;
    assign mismatch = mismatch_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_led_pattern_master.sv
// Bench for led_pattern_master: LED slave model, expected-transaction queue and an independent bus monitor.
module tb_led_pattern_master;

    localparam int unsigned PERIOD   = 4;
    localparam int unsigned TIMEOUT  = 8;
    localparam logic [31:0] LED_ADDR = 32'h0000_0040;

    typedef struct packed {
        logic [7:0] wdat;
        logic       mm;
        logic       to;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, enable, clear;
    logic [31:0] avm_m0_address, avm_m0_writedata, avm_m0_readdata;
    logic        avm_m0_read, avm_m0_write, avm_m0_waitrequest, avm_m0_readdatavalid;
    logic [7:0]  pattern;
    logic        busy, mismatch, timeout;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    int          wr_acc_cnt = 0;
    int          rd_acc_cnt = 0;
    int          stall_cfg = 0;
    bit          no_rdv = 1'b0;
    logic [7:0]  corrupt_pat = 8'h00;
    int          exp_hold = 1;
    int          exp_spacing = 8;
    int          run_id = 0;

    int          stall_cnt = 0;
    bit          rd_acc_prev = 1'b0;
    logic [7:0]  led_reg = 8'h00;

    always #5 clk = ~clk;

    led_pattern_master #(
        .PERIOD   (PERIOD),
        .TIMEOUT  (TIMEOUT),
        .LED_ADDR (LED_ADDR)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .enable               (enable),
        .clear                (clear),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_write         (avm_m0_write),
        .avm_m0_writedata     (avm_m0_writedata),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .pattern              (pattern),
        .busy                 (busy),
        .mismatch             (mismatch),
        .timeout              (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic mm, input logic to);
        exp_t e;
        e.wdat = d;
        e.mm   = mm;
        e.to   = to;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wr(input int n, input string name);
        int k = 0;
        while (wr_acc_cnt < n && k < 300) begin
            tick();
            k++;
        end
        if (wr_acc_cnt < n) begin
            checks++;
            failures++;
            $display("FAIL %s: timed out with %0d write accepts, expected %0d", name, wr_acc_cnt, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        check(name, {31'b0, busy}, 32'd0);
    endtask

    // LED slave: stall_cfg wait cycles per command, 1-cycle read latency, optional corruption.
    initial begin
        avm_m0_waitrequest   = 1'b0;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_readdata      = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            avm_m0_readdatavalid = rd_acc_prev && !no_rdv;
            avm_m0_readdata = {24'hA5A5A5, led_reg ^ ((led_reg == corrupt_pat) ? 8'h10 : 8'h00)};
            if ((avm_m0_write || avm_m0_read) && stall_cnt < stall_cfg) begin
                avm_m0_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                avm_m0_waitrequest = 1'b0;
                stall_cnt = 0;
            end
            rd_acc_prev = avm_m0_read && !avm_m0_waitrequest;
            if (avm_m0_write && !avm_m0_waitrequest) led_reg = avm_m0_writedata[7:0];
        end
    end

    initial begin : monitor
        exp_t        cur;
        int          wr_len, rd_len, rw_cnt, cyc, last_wr_cyc, last_run;
        bit          pend, chk_due;
        logic [31:0] wr_addr0, wr_dat0, rd_addr0;
        cur = '0;
        wr_len = 0; rd_len = 0; rw_cnt = 0; cyc = 0; last_wr_cyc = 0; last_run = -1;
        pend = 1'b0; chk_due = 1'b0;
        wr_addr0 = '0; wr_dat0 = '0; rd_addr0 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                pend = 1'b0; chk_due = 1'b0; wr_len = 0; rd_len = 0;
                continue;
            end
            check("rd_wr_exclusive", {31'b0, avm_m0_read & avm_m0_write}, 32'd0);
            if (!avm_m0_read && !avm_m0_write) check("addr_idle", avm_m0_address, 32'd0);

            if (chk_due) begin
                check("check_mismatch", {31'b0, mismatch}, {31'b0, cur.mm});
                check("check_timeout", {31'b0, timeout}, {31'b0, cur.to});
                check("check_busy", {31'b0, busy}, 32'd1);
                chk_due = 1'b0;
            end else if (pend) begin
                rw_cnt++;
                if (avm_m0_readdatavalid || rw_cnt == TIMEOUT) begin
                    pend = 1'b0;
                    chk_due = 1'b1;
                end
            end

            if (avm_m0_write) begin
                wr_len++;
                if (wr_len == 1) begin
                    wr_addr0 = avm_m0_address;
                    wr_dat0  = avm_m0_writedata;
                end else begin
                    check("wr_addr_stable", avm_m0_address, wr_addr0);
                    check("wr_data_stable", avm_m0_writedata, wr_dat0);
                end
                if (!avm_m0_waitrequest) begin
                    check("wr_hold_cycles", wr_len, exp_hold);
                    check("wr_addr", avm_m0_address, LED_ADDR);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got data %0h, expected no write", avm_m0_writedata);
                    end else begin
                        cur = exp_q.pop_front();
                        check("wr_data", avm_m0_writedata, {24'b0, cur.wdat});
                    end
                    if (last_run == run_id) check("wr_spacing", cyc - last_wr_cyc, exp_spacing);
                    last_run    = run_id;
                    last_wr_cyc = cyc;
                    wr_acc_cnt++;
                    wr_len = 0;
                end
            end else begin
                wr_len = 0;
            end

            if (avm_m0_read) begin
                rd_len++;
                if (rd_len == 1) rd_addr0 = avm_m0_address;
                else check("rd_addr_stable", avm_m0_address, rd_addr0);
                if (!avm_m0_waitrequest) begin
                    check("rd_hold_cycles", rd_len, exp_hold);
                    check("rd_addr", avm_m0_address, LED_ADDR);
                    rd_acc_cnt++;
                    rd_len = 0;
                    pend   = 1'b1;
                    rw_cnt = 0;
                end
            end else begin
                rd_len = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        repeat (3) tick();
        check("rst_write", {31'b0, avm_m0_write}, 32'd0);
        check("rst_read", {31'b0, avm_m0_read}, 32'd0);
        check("rst_address", avm_m0_address, 32'd0);
        check("rst_writedata", avm_m0_writedata, 32'd0);
        check("rst_pattern", {24'b0, pattern}, 32'h01);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_flags", {30'b0, mismatch, timeout}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Free-running walk, zero-wait slave.
        exp_hold = 1; exp_spacing = 8; run_id = 1;
        push(8'h01, 1'b0, 1'b0); push(8'h02, 1'b0, 1'b0); push(8'h04, 1'b0, 1'b0);
        push(8'h08, 1'b0, 1'b0); push(8'h10, 1'b0, 1'b0); push(8'h20, 1'b0, 1'b0);
        push(8'h40, 1'b0, 1'b0); push(8'h80, 1'b0, 1'b0); push(8'h01, 1'b0, 1'b0);
        enable = 1'b1;
        tick();
        check("first_write_issued", {31'b0, avm_m0_write}, 32'd1);
        check("busy_running", {31'b0, busy}, 32'd1);
        wait_wr(9, "walk_writes");
        enable = 1'b0;
        wait_idle("walk_idle");
        check("walk_pattern", {24'b0, pattern}, 32'h02);
        check("walk_mismatch", {31'b0, mismatch}, 32'd0);
        check("walk_reads", rd_acc_cnt, 32'd9);

        // Three wait cycles on both the write and the read.
        stall_cfg = 3; exp_hold = 4; run_id = 2;
        push(8'h02, 1'b0, 1'b0);
        enable = 1'b1;
        wait_wr(10, "stall_write");
        enable = 1'b0;
        wait_idle("stall_idle");
        check("stall_pattern", {24'b0, pattern}, 32'h04);
        check("stall_reads", rd_acc_cnt, 32'd10);

        // Enable dropped while the write is stalled.
        run_id = 3;
        push(8'h04, 1'b0, 1'b0);
        enable = 1'b1;
        k = 0;
        while (!avm_m0_write && k < 20) begin tick(); k++; end
        check("drop_write_seen", {31'b0, avm_m0_write}, 32'd1);
        enable = 1'b0;
        wait_idle("drop_idle");
        check("drop_pattern", {24'b0, pattern}, 32'h08);
        check("drop_writes", wr_acc_cnt, 32'd11);
        check("drop_reads", rd_acc_cnt, 32'd11);

        // Corrupted readback on the second pattern, then clear.
        stall_cfg = 0; exp_hold = 1; exp_spacing = 8; run_id = 4; corrupt_pat = 8'h10;
        push(8'h08, 1'b0, 1'b0); push(8'h10, 1'b1, 1'b0);
        enable = 1'b1;
        wait_wr(13, "mm_writes");
        enable = 1'b0;
        wait_idle("mm_idle");
        check("mm_pattern", {24'b0, pattern}, 32'h20);
        check("mm_sticky", {31'b0, mismatch}, 32'd1);
        corrupt_pat = 8'h00;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("mm_cleared", {31'b0, mismatch}, 32'd0);

        // Slave never returns data.
        no_rdv = 1'b1; exp_spacing = 15; run_id = 5;
        push(8'h20, 1'b0, 1'b1); push(8'h40, 1'b0, 1'b1);
        enable = 1'b1;
        wait_wr(15, "to_writes");
        enable = 1'b0;
        wait_idle("to_idle");
        check("to_pattern", {24'b0, pattern}, 32'h80);
        check("to_flag", {31'b0, timeout}, 32'd1);
        no_rdv = 1'b0;

        // Asynchronous reset during a stalled read.
        stall_cfg = 50; exp_hold = 51; run_id = 6;
        push(8'h80, 1'b0, 1'b0);
        enable = 1'b1;
        wait_wr(16, "rst_mid_write");
        k = 0;
        while (!avm_m0_read && k < 20) begin tick(); k++; end
        check("rst_mid_read_seen", {31'b0, avm_m0_read}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_read_drop", {31'b0, avm_m0_read}, 32'd0);
        check("rst_mid_address", avm_m0_address, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        enable = 1'b0;
        stall_cfg = 0;
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_pattern", {24'b0, pattern}, 32'h01);
        check("post_rst_flags", {30'b0, mismatch, timeout}, 32'd0);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_master.md
# led_pattern_master

Avalon-MM master that drives the LED peripheral from the initiator side. It writes a walking-one pattern to the LED data register, reads the register back over the same bus, and compares the readback. It then waits a programmable interval and advances the pattern. It sits in the FPGA fabric as a self-test and demo master, and connects through the interconnect to any slave exposing an 8-bit LED register at word offset 0.

## Interface
- `PERIOD`, default 50_000_000: idle cycles between pattern updates; legal range ≥ 2.
- `TIMEOUT`, default 256: maximum cycles to wait for `avm_m0_readdatavalid`; legal range ≥ 1.
- `LED_ADDR`, default 32'h0000_0000: byte address of the LED data register.
- `clk`, input, 1: system clock. All logic is in this single clock domain.
- `reset_n`, input, 1: reset, asynchronous assert and active-low.
- `enable`, input, 1: run request. Level-sensitive.
- `clear`, input, 1: single-cycle pulse that clears the sticky status flags.
- `avm_m0_address`, output, 32: bus address.
- `avm_m0_read`, output, 1: read command.
- `avm_m0_write`, output, 1: write command.
- `avm_m0_writedata`, output, 32: write data, equal to {24'b0, `pattern`}.
- `avm_m0_readdata`, input, 32: read data.
- `avm_m0_waitrequest`, input, 1: slave stall.
- `avm_m0_readdatavalid`, input, 1: read data valid.
- `pattern`, output, 8: pattern currently being driven or checked.
- `busy`, output, 1: high in any state other than IDLE.
- `mismatch`, output, 1: sticky flag; readback differed from `pattern`.
- `timeout`, output, 1: sticky flag; `avm_m0_readdatavalid` did not arrive within TIMEOUT cycles.

## Operation
- States and transitions:
  - IDLE → WRITE when `enable`=1.
  - WRITE → READ on write accept.
  - READ → RDWAIT on read accept.
  - RDWAIT → CHECK on `avm_m0_readdatavalid`. If TIMEOUT cycles elapse with no `avm_m0_readdatavalid`, set `timeout` and go → CHECK without comparing.
  - CHECK → WAIT if `enable`=1, otherwise → IDLE.
  - WAIT → WRITE after PERIOD cycles. If `enable` drops during WAIT, go → IDLE on the next cycle.
- Accept rule: a command is accepted in a cycle where it is asserted and `avm_m0_waitrequest`=0.
  - While `avm_m0_waitrequest`=1, hold `avm_m0_read`/`avm_m0_write`, address and data stable.
  - `avm_m0_read` and `avm_m0_write` are never high together.
- Address: `avm_m0_address` = LED_ADDR in WRITE and READ; otherwise 0.
- Compare: in RDWAIT, when `avm_m0_readdatavalid`=1, compare `avm_m0_readdata[7:0]` with `pattern`. On inequality, set `mismatch`. Ignore `avm_m0_readdata[31:8]`.
- Pattern update in CHECK: rotate left by 1. 8'h80 wraps to 8'h01.
- Stopping: `enable` dropping during WRITE, READ or RDWAIT does not abort the transaction. The transaction completes, and the block goes to IDLE from CHECK.
- Flags:
  - `clear` clears `mismatch` and `timeout` in the next cycle.
  - If `clear` coincides with a new set event, the set wins.
- `avm_m0_readdatavalid` outside RDWAIT is ignored.
- Reset values:
  - state IDLE, `pattern`=8'h01, all bus command outputs 0.
  - `avm_m0_address`=0, `avm_m0_writedata`=0.
  - `busy`, `mismatch` and `timeout` all 0.
  - counters 0.
- Reset mid-transaction: outputs drop to their reset values immediately on the asynchronous assert. The slave sees the command withdrawn.

## Timing
- All outputs are registered.
- From `enable` rising in IDLE, `avm_m0_write` is asserted on the next clock edge.
- With `avm_m0_waitrequest`=0 throughout:
  - WRITE lasts 1 cycle, READ lasts 1 cycle.
  - RDWAIT lasts the slave read latency (≥1 cycle).
  - CHECK lasts 1 cycle.
  - WAIT lasts exactly PERIOD cycles.
- Consecutive write-accept edges are therefore 4 + PERIOD + (latency − 1) cycles apart.
- `mismatch` and `timeout` are visible in the CHECK cycle.
- `pattern` updates on the CHECK→next edge.
- Wait counter: width $clog2(PERIOD); loaded with PERIOD−1 on CHECK exit; leave WAIT when the count is 0.
- Timeout counter: width $clog2(TIMEOUT+1); reset on READ accept.

## Structure
- Shared package `led_master_pkg`:
  - state enum `led_master_state_t` (IDLE, WRITE, READ, RDWAIT, CHECK, WAIT).
  - `LED_PATTERN_INIT` = 8'h01.
  - `LED_REG_OFFSET` = 0.
- One natural sub-module: `avm_single_master`. It is a generic one-outstanding-transaction Avalon-MM initiator covering accept logic, readdatavalid capture and timeout. The FSM issues requests to it.

## Test plan
- PERIOD=4, zero-wait slave with 1-cycle read latency, `enable`=1:
  - writes are 8'h01, 8'h02, 8'h04 … 8'h80, 8'h01, with accepts exactly 8 cycles apart.
  - `mismatch`=0 throughout.
- Slave holds `avm_m0_waitrequest` for 3 cycles on both the write and the read: command, address and data stay stable for 4 cycles each; exactly one write and one read per pattern.
- Slave returns `pattern` XOR 8'h10 on the second pattern:
  - `mismatch`=1 in the CHECK cycle and stays 1.
  - a `clear` pulse clears it the following cycle.
- Slave never asserts `avm_m0_readdatavalid`, TIMEOUT=8: `timeout`=1 after 8 RDWAIT cycles, then FSM → WAIT and the pattern still advances.
- `enable` drops while the write is stalled: write completes, read completes, then IDLE with `busy`=0 and `pattern` advanced by one.
- `reset_n` asserted low during a stalled read:
  - `avm_m0_read` drops to 0 with no clock edge required.
  - after release, `pattern`=8'h01 and flags are 0.
